wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the writeback stage and a long-latency unit.
// Optional starvation guard (wait counter, stall_req, err) is enabled by WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        stall_req,
  output logic        err
);

  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;

  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        grant_pipe, grant_fifo, grant_any;
  logic        stall_active;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;

  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);
  assign lu_ready   = ~fifo_full;
  assign push       = lu_valid & ~fifo_full;

  // A stall cycle belongs to the FIFO head; a pipeline result offered then is dropped.
  always_comb begin
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (stall_active) begin
      grant_fifo = ~fifo_empty;
    end else if (pipe_valid) begin
      grant_pipe = 1'b1;
    end else begin
      grant_fifo = ~fifo_empty;
    end
  end

  assign pop       = grant_fifo;
  assign grant_any = grant_pipe | grant_fifo;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= lu_rd;
        fifo_data_q[wr_ptr_q] <= lu_data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign win_rd   = grant_fifo ? fifo_rd_q[rd_ptr_q]   : pipe_rd;
  assign win_data = grant_fifo ? fifo_data_q[rd_ptr_q] : pipe_data;

  // Writes to x0 still consume the grant but never reach the register file.
  always_comb begin
    rf_we_d = grant_any & (win_rd != 5'd0);
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (grant_any) begin
      rf_rd_d = win_rd;
      rf_wd_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= 5'd0;
      rf_wd_q <= 32'd0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_wd = rf_wd_q;

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned WaitW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             stall_q, stall_d;
  logic             err_q, err_d;

  always_comb begin
    wait_d  = wait_q + 1'b1;
    stall_d = 1'b0;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q == WaitW'(STARVE_LIMIT - 1)) begin
      stall_d = 1'b1;
    end
    err_d = err_q | (stall_q & pipe_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_active = stall_q;
  assign stall_req    = stall_q;
  assign err          = err_q;
`else
  assign stall_active = 1'b0;
  assign stall_req    = 1'b0;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes go to a queue, a negedge monitor checks them.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .stall_req  (stall_req),
    .err        (err)
  );

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d wd=%08h, required no write", rf_rd, rf_wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_rd, rf_wd} !== e) begin
          n_err++;
          $display("FAIL write: got rd=%0d wd=%08h, required rd=%0d wd=%08h",
                   rf_rd, rf_wd, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic cyc(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    lu_valid   = lv;
    lu_rd      = lrd;
    lu_data    = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_rd", 32'(rf_rd), 32'd0);
    chk("reset_rf_wd", rf_wd, 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b1;
    idle(1);
    chk("release_lu_ready", 32'(lu_ready), 32'd1);

    // Pipeline-only write
    expect_wr(5'd5, 32'h1234);
    cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("pipe_rf_we", 32'(rf_we), 32'd1);
    idle(2);

    // LU result while pipeline idle
    chk("lu_idle_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd7, 32'hAA);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    idle(3);

    // Pipeline write to x0 is suppressed
    cyc(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    idle(2);

    // Contention: pipeline busy with one queued LU result
`ifdef WB_ARB_STARVE_EN
    for (int k = 0; k < 5; k++) begin
      expect_wr(5'd1, 32'h100 + 32'(k));
      cyc(1'b1, 5'd1, 32'h100 + 32'(k), (k == 0), 5'd9, 32'hBEEF);
      chk($sformatf("contend_stall_%0d", k), 32'(stall_req), (k == 4) ? 32'd1 : 32'd0);
    end
    expect_wr(5'd9, 32'hBEEF);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("contend_stall_end", 32'(stall_req), 32'd0);
    chk("contend_err", 32'(err), 32'd0);
    idle(3);
`else
    for (int k = 0; k < 8; k++) begin
      expect_wr(5'd1, 32'h100 + 32'(k));
      cyc(1'b1, 5'd1, 32'h100 + 32'(k), (k == 0), 5'd9, 32'hBEEF);
      chk($sformatf("contend_stall_%0d", k), 32'(stall_req), 32'd0);
    end
    chk("contend_queued_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd9, 32'hBEEF);
    idle(3);
`endif

    // Full FIFO with the pipeline busy, third LU offer held
    expect_wr(5'd2, 32'h300);
    cyc(1'b1, 5'd2, 32'h300, 1'b1, 5'd10, 32'hA0);
    chk("full_ready_1", 32'(lu_ready), 32'd1);
    expect_wr(5'd2, 32'h301);
    cyc(1'b1, 5'd2, 32'h301, 1'b1, 5'd11, 32'hA1);
    chk("full_ready_2", 32'(lu_ready), 32'd0);
    expect_wr(5'd2, 32'h302);
    cyc(1'b1, 5'd2, 32'h302, 1'b1, 5'd12, 32'hA2);
    chk("full_ready_3", 32'(lu_ready), 32'd0);
    expect_wr(5'd10, 32'hA0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2);
    chk("full_ready_after_pop", 32'(lu_ready), 32'd1);
    expect_wr(5'd11, 32'hA1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2);
    expect_wr(5'd12, 32'hA2);
    idle(3);
    chk("full_stall", 32'(stall_req), 32'd0);

    // Protocol violation: pipeline valid during a stall cycle
`ifdef WB_ARB_STARVE_EN
    for (int k = 0; k < 5; k++) begin
      expect_wr(5'd1, 32'h200 + 32'(k));
      cyc(1'b1, 5'd1, 32'h200 + 32'(k), (k == 0), 5'd13, 32'hC3);
    end
    chk("proto_stall", 32'(stall_req), 32'd1);
    expect_wr(5'd13, 32'hC3);
    cyc(1'b1, 5'd1, 32'h205, 1'b0, 5'd0, 32'd0);
    chk("proto_err", 32'(err), 32'd1);
    idle(3);
    chk("proto_err_sticky", 32'(err), 32'd1);
`else
    chk("proto_err_tied", 32'(err), 32'd0);
`endif

    // Reset with two queued entries
    expect_wr(5'd3, 32'h400);
    cyc(1'b1, 5'd3, 32'h400, 1'b1, 5'd20, 32'hD0);
    expect_wr(5'd3, 32'h401);
    cyc(1'b1, 5'd3, 32'h401, 1'b1, 5'd21, 32'hD1);
    chk("prereset_full", 32'(lu_ready), 32'd0);
    pipe_valid = 1'b0;
    lu_valid   = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_lu_ready", 32'(lu_ready), 32'd1);
    chk("midreset_rf_we", 32'(rf_we), 32'd0);
    chk("midreset_rf_wd", rf_wd, 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    chk("postreset_lu_ready", 32'(lu_ready), 32'd1);
    chk("postreset_rf_we", 32'(rf_we), 32'd0);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
